// File: rtl/processador_pkg.sv
// processador_pkg: shared widths, condition codes and fetch-unit states
package processador_pkg;
    localparam int AW = 8;
    localparam int IW = 17;
    typedef enum logic [2:0] {
        COND_SEMPRE = 3'b000,
        COND_Z      = 3'b001,
        COND_L      = 3'b010,
        COND_LE     = 3'b011,
        COND_E      = 3'b100,
        COND_GE     = 3'b101,
        COND_G      = 3'b110,
        COND_NUNCA  = 3'b111
    } cond_t;
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} busca_estado_t;
endpackage

// File: rtl/avaliador_condicao.sv
// avaliador_condicao: selects the ALU flag named by a jump condition code
module avaliador_condicao (
    input  logic [2:0] COND,
    input  logic       Z,
    input  logic       L,
    input  logic       LE,
    input  logic       E,
    input  logic       GE,
    input  logic       G,
    output logic       taken
);
    logic [7:0] tabela;
    assign tabela = {1'b0, G, GE, E, LE, L, Z, 1'b1};
    assign taken  = tabela[COND];
endmodule

// File: rtl/unidade_busca.sv
// unidade_busca: PC owner, program-memory fetch and one-word instruction buffer
module unidade_busca
    import processador_pkg::*;
(
    input  logic          CLK,
    input  logic          RESET,
    output logic          MEM_REQ,
    output logic [AW-1:0] MEM_ADDR,
    input  logic          MEM_ACK,
    input  logic [IW-1:0] MEM_DATA,
    output logic [IW-1:0] C,
    output logic [AW-1:0] INSTR_PC,
    output logic          INSTR_VALID,
    input  logic          INSTR_READY,
    input  logic          REDIRECT,
    input  logic [2:0]    COND,
    input  logic [AW-1:0] TARGET,
    input  logic          Z,
    input  logic          L,
    input  logic          LE,
    input  logic          E,
    input  logic          GE,
    input  logic          G,
    output logic [AW-1:0] PC
);
    busca_estado_t estado, nxt;
    logic [AW-1:0] pc_nxt, end_pend;
    logic          cond_ok, salto, carrega;
    avaliador_condicao u_cond (
        .COND (COND),
        .Z    (Z),
        .L    (L),
        .LE   (LE),
        .E    (E),
        .GE   (GE),
        .G    (G),
        .taken(cond_ok)
    );
    assign salto    = REDIRECT & cond_ok;
    // an outstanding request keeps its original address even after the PC is redirected
    assign MEM_ADDR = (estado == DISCARD) ? end_pend : PC;
    // state register
    always_ff @(posedge CLK) begin
        estado <= RESET ? IDLE : nxt;
    end
    // next state, next PC and buffer load decision
    always_comb begin
        nxt     = estado;
        pc_nxt  = PC;
        carrega = 1'b0;
        case (estado)
            IDLE: nxt = FETCH;
            FETCH: begin
                if (MEM_ACK && !salto) begin
                    nxt     = HOLD;
                    carrega = 1'b1;
                    pc_nxt  = PC + AW'(1);
                end else if (salto) begin
                    nxt    = MEM_ACK ? FETCH : DISCARD;
                    pc_nxt = TARGET;
                end
            end
            HOLD: begin
                nxt    = (salto || INSTR_READY) ? FETCH : HOLD;
                pc_nxt = salto ? TARGET : PC;
            end
            DISCARD: begin
                nxt    = MEM_ACK ? FETCH : DISCARD;
                pc_nxt = salto ? TARGET : PC;
            end
            default: nxt = IDLE;
        endcase
    end
    // registered outputs, PC and the address of the pending request
    always_ff @(posedge CLK) begin
        if (RESET) begin
            PC          <= '0;
            C           <= '0;
            INSTR_PC    <= '0;
            INSTR_VALID <= 1'b0;
            MEM_REQ     <= 1'b0;
            end_pend    <= '0;
        end else begin
            PC          <= pc_nxt;
            INSTR_VALID <= (nxt == HOLD);
            MEM_REQ     <= (nxt == FETCH) || (nxt == DISCARD);
            if (carrega) begin
                C        <= MEM_DATA;
                INSTR_PC <= PC;
            end
            if (estado == FETCH) end_pend <= PC;
        end
    end
endmodule

// File: tb/tb_unidade_busca.sv
// tb_unidade_busca: directed stimulus with an instruction scoreboard for unidade_busca
module tb_unidade_busca;
    import processador_pkg::*;
    logic          CLK, RESET, MEM_REQ, MEM_ACK, INSTR_VALID, INSTR_READY, REDIRECT;
    logic [AW-1:0] MEM_ADDR, INSTR_PC, TARGET, PC;
    logic [IW-1:0] MEM_DATA, C;
    logic [2:0]    COND;
    logic          Z, L, LE, E, GE, G;
    int            n_cmp = 0, n_bad = 0, hs_cnt = 0, lat = 0, cnt = 0;
    logic [IW+AW-1:0] q[$];

    unidade_busca dut (
        .CLK(CLK), .RESET(RESET), .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA), .C(C), .INSTR_PC(INSTR_PC),
        .INSTR_VALID(INSTR_VALID), .INSTR_READY(INSTR_READY), .REDIRECT(REDIRECT),
        .COND(COND), .TARGET(TARGET), .Z(Z), .L(L), .LE(LE), .E(E), .GE(GE), .G(G),
        .PC(PC)
    );

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [IW-1:0] c, input logic [AW-1:0] pc);
        q.push_back({c, pc});
    endtask

    // program memory: answers after lat wait cycles with data = address + 0x100
    initial begin
        MEM_ACK  = 0;
        MEM_DATA = '0;
        forever begin
            @(posedge CLK);
            #2;
            if (MEM_REQ) begin
                if (cnt >= lat) begin
                    MEM_ACK  = 1;
                    MEM_DATA = IW'(MEM_ADDR) + IW'('h100);
                    cnt      = 0;
                end else begin
                    MEM_ACK = 0;
                    cnt++;
                end
            end else begin
                MEM_ACK = 0;
                cnt     = 0;
            end
        end
    end

    // monitor: every accepted instruction is checked against the scoreboard
    initial begin
        forever begin
            @(negedge CLK);
            if (INSTR_VALID && INSTR_READY) begin
                logic [IW+AW-1:0] e;
                hs_cnt++;
                n_cmp++;
                if (q.size() == 0) begin
                    n_bad++;
                    $display("FAIL instr_extra: got C=%h pc=%h expected none", C, INSTR_PC);
                end else begin
                    e = q.pop_front();
                    if ({C, INSTR_PC} !== e) begin
                        n_bad++;
                        $display("FAIL instr: got C=%h pc=%h expected C=%h pc=%h",
                                 C, INSTR_PC, e[IW+AW-1:AW], e[AW-1:0]);
                    end
                end
            end
        end
    end

    initial begin
        RESET = 1; INSTR_READY = 0; REDIRECT = 0; COND = COND_SEMPRE; TARGET = '0;
        Z = 0; L = 0; LE = 0; E = 0; GE = 0; G = 0;
        tick(3);
        chk("rst_req", MEM_REQ, 0);
        chk("rst_addr", MEM_ADDR, 0);
        chk("rst_c", C, 0);
        chk("rst_ipc", INSTR_PC, 0);
        chk("rst_valid", INSTR_VALID, 0);
        chk("rst_pc", PC, 0);
        push(17'h100, 8'h00); push(17'h101, 8'h01); push(17'h102, 8'h02);
        RESET = 0; INSTR_READY = 1;
        chk("idle_req", MEM_REQ, 0);
        tick(1);
        chk("first_req", MEM_REQ, 1);
        chk("first_addr", MEM_ADDR, 0);
        tick(5);
        chk("rate_hs2", hs_cnt, 2);
        tick(1);
        chk("rate_hs3", hs_cnt, 3);
        lat = 3; INSTR_READY = 0; push(17'h103, 8'h03);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("wait_req", MEM_REQ, 1);
            chk("wait_addr", MEM_ADDR, 3);
            chk("wait_valid", INSTR_VALID, 0);
        end
        chk("c_hold", C, 17'h102);
        tick(1);
        chk("ack_valid", INSTR_VALID, 1);
        chk("ack_c", C, 17'h103);
        chk("ack_ipc", INSTR_PC, 3);
        chk("ack_noreq", MEM_REQ, 0);
        tick(1);
        chk("stall_valid", INSTR_VALID, 1);
        chk("stall_noreq", MEM_REQ, 0);
        INSTR_READY = 1; lat = 0;
        tick(1);
        INSTR_READY = 0;
        tick(1);
        chk("hold_valid", INSTR_VALID, 1);
        chk("hold_c", C, 17'h104);
        REDIRECT = 1; COND = COND_Z; Z = 1; TARGET = 8'h40;
        tick(1);
        REDIRECT = 0; Z = 0;
        chk("flush_valid", INSTR_VALID, 0);
        chk("flush_addr", MEM_ADDR, 8'h40);
        chk("flush_req", MEM_REQ, 1);
        tick(1);
        chk("jmp_c", C, 17'h140);
        chk("jmp_ipc", INSTR_PC, 8'h40);
        REDIRECT = 1; COND = COND_Z; Z = 0; TARGET = 8'h55;
        tick(1);
        chk("nt_valid", INSTR_VALID, 1);
        chk("nt_c", C, 17'h140);
        chk("nt_pc", PC, 8'h41);
        chk("nt_req", MEM_REQ, 0);
        REDIRECT = 0; INSTR_READY = 1; lat = 2; push(17'h140, 8'h40);
        tick(1);
        chk("f41_addr", MEM_ADDR, 8'h41);
        REDIRECT = 1; COND = COND_SEMPRE; TARGET = 8'h80;
        tick(1);
        chk("disc_req", MEM_REQ, 1);
        chk("disc_addr", MEM_ADDR, 8'h41);
        chk("disc_pc", PC, 8'h80);
        TARGET = 8'h90;
        tick(1);
        REDIRECT = 0;
        chk("disc2_addr", MEM_ADDR, 8'h41);
        chk("disc2_pc", PC, 8'h90);
        tick(1);
        chk("post_disc_addr", MEM_ADDR, 8'h90);
        chk("post_disc_req", MEM_REQ, 1);
        chk("post_disc_valid", INSTR_VALID, 0);
        lat = 0; push(17'h190, 8'h90);
        tick(1);
        chk("h90_valid", INSTR_VALID, 1);
        REDIRECT = 1; COND = COND_SEMPRE; TARGET = 8'hFF; push(17'h1FF, 8'hFF);
        tick(1);
        REDIRECT = 0;
        chk("ff_addr", MEM_ADDR, 8'hFF);
        chk("ff_valid", INSTR_VALID, 0);
        tick(2);
        chk("wrap_addr", MEM_ADDR, 8'h00);
        chk("wrap_pc", PC, 8'h00);
        REDIRECT = 1; COND = COND_G; G = 1; TARGET = 8'h20; push(17'h120, 8'h20);
        tick(1);
        REDIRECT = 0; G = 0;
        chk("drop_addr", MEM_ADDR, 8'h20);
        chk("drop_req", MEM_REQ, 1);
        chk("drop_valid", INSTR_VALID, 0);
        tick(1);
        lat = 5;
        tick(1);
        chk("f21_addr", MEM_ADDR, 8'h21);
        REDIRECT = 1; COND = COND_SEMPRE; TARGET = 8'h33;
        tick(1);
        chk("rd_req", MEM_REQ, 1);
        chk("rd_addr", MEM_ADDR, 8'h21);
        chk("rd_pc", PC, 8'h33);
        REDIRECT = 0; RESET = 1;
        tick(1);
        chk("rr_req", MEM_REQ, 0);
        chk("rr_addr", MEM_ADDR, 0);
        chk("rr_c", C, 0);
        chk("rr_ipc", INSTR_PC, 0);
        chk("rr_valid", INSTR_VALID, 0);
        chk("rr_pc", PC, 0);
        RESET = 0; lat = 0; push(17'h100, 8'h00);
        tick(1);
        chk("restart_req", MEM_REQ, 1);
        chk("restart_addr", MEM_ADDR, 0);
        tick(2);
        INSTR_READY = 0;
        tick(3);
        chk("drain", q.size(), 0);
        chk("hs_total", hs_cnt, 9);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/unidade_busca.md
# unidade_busca

Instruction fetch unit of the 8-bit processor: the supply end of the 17-bit instruction word `C[16:0]` that `unidadeDeControle` decodes. It owns the program counter and reads a 256 x 17 program memory through a request/acknowledge handshake. It holds one fetched word in a buffer and presents it to the control unit through a valid/ready handshake. It also accepts flag-conditioned jump redirects from the control unit, flushing stale fetches.

## Interface
- `AW`, 8: program address width; the PC wraps at 2^AW.
- `IW`, 17: instruction word width.
- `CLK`  in  1  single clock; all state updates on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `MEM_REQ`  out  1  fetch request; held high until `MEM_ACK`.
- `MEM_ADDR`  out  AW  fetch address; stable while `MEM_REQ` is high.
- `MEM_ACK`  in  1  memory acknowledges; `MEM_DATA` is valid in the same cycle.
- `MEM_DATA`  in  IW  fetched word.
- `C`  out  IW  buffered instruction to the control unit.
- `INSTR_PC`  out  AW  address of the word on `C`.
- `INSTR_VALID`  out  1  `C` holds a valid instruction.
- `INSTR_READY`  in  1  the control unit accepts `C` this cycle.
- `REDIRECT`  in  1  the control unit requests a jump this cycle.
- `COND`  in  3  jump condition code.
- `TARGET`  in  AW  jump destination (the control unit's `A`).
- `Z`, `L`, `LE`, `E`, `GE`, `G`  in  1 each  ALU flags.
- `PC`  out  AW  address of the next fetch.

## Operation
- Condition codes: 000 always, 001 Z, 010 L, 011 LE, 100 E, 101 GE, 110 G, 111 never. A redirect is taken when `REDIRECT` is high and the selected condition is true. An untaken redirect has no effect.
- The state machine has four states: IDLE, FETCH, HOLD and DISCARD.
- IDLE: entered on reset. Moves to FETCH unconditionally on the next cycle.
- FETCH: `MEM_REQ`=1 and `MEM_ADDR`=`PC`.
  - On `MEM_ACK` without a taken redirect: `C`<=`MEM_DATA`, `INSTR_PC`<=`PC`, `PC`<=`PC`+1, `INSTR_VALID`<=1, then go to HOLD.
  - On a taken redirect without `MEM_ACK`: `PC`<=`TARGET`, then go to DISCARD.
  - On a taken redirect together with `MEM_ACK`: the data is dropped, `PC`<=`TARGET`, and the state stays FETCH.
- HOLD: `MEM_REQ`=0 and `INSTR_VALID`=1.
  - On handshake (`INSTR_VALID` & `INSTR_READY`): `INSTR_VALID`<=0, then go to FETCH.
  - On a taken redirect, with or without handshake: `INSTR_VALID`<=0, `PC`<=`TARGET`, then go to FETCH. When a handshake coincides with the redirect, the instruction counts as accepted.
- DISCARD: `MEM_REQ` stays 1 with the old `MEM_ADDR`, because a request is never withdrawn.
  - On `MEM_ACK`: the data is dropped and the state goes to FETCH; `MEM_ADDR` then shows the new `PC`.
  - On a further taken redirect: `PC`<=the newest `TARGET`.
- The PC increments modulo 2^AW: 255+1 = 0.
- `C` and `INSTR_PC` hold their value while `INSTR_VALID`=0.

## Timing
- Reset values (synchronous; reset overrides every other input, including in any state and mid-request): state=IDLE, `PC`=0, `MEM_REQ`=0, `MEM_ADDR`=0, `C`=0, `INSTR_PC`=0, `INSTR_VALID`=0.
- The first `MEM_REQ` rises in the second cycle after `RESET` falls, with `MEM_ADDR`=0.
- `MEM_ACK` in cycle N gives `INSTR_VALID`=1 in cycle N+1.
- A handshake in cycle N gives `MEM_REQ`=1 in cycle N+1.
- Throughput is one instruction per (memory latency + 2) cycles. With zero-wait memory (ack in the first request cycle) this is one instruction every 2 cycles.
- A taken redirect in cycle N gives `MEM_ADDR`=`TARGET` in cycle N+1 from FETCH-with-ack or HOLD. From DISCARD it takes effect in the cycle after the outstanding ack.
- A dropped word never asserts `INSTR_VALID`.
- All outputs are registered, except `MEM_ADDR`, which is decoded from state and `PC`. There is no combinational path from inputs to outputs.

## Structure
- Shared package `processador_pkg` holds:
  - the constants `AW` and `IW`;
  - the `cond_t` enum for the 3-bit condition codes;
  - the `busca_estado_t` enum {IDLE, FETCH, HOLD, DISCARD}.
- One combinational sub-module, `avaliador_condicao`: inputs `COND` and the six flags, output `taken`. The control unit reuses it.

## Test plan
- Reset, then zero-wait memory returning `MEM_DATA`=addr+0x100 with `INSTR_READY`=1 -> `C`=0x100, 0x101, 0x102 one every 2 cycles, with `INSTR_PC`=0,1,2.
- Ack delayed 3 cycles with `INSTR_READY` held 0 for 5 cycles -> `MEM_REQ` and `MEM_ADDR` stay stable until ack; `C` and `INSTR_VALID` hold; no second request is issued.
- In HOLD, `REDIRECT`=1, `COND`=001, `Z`=1, `TARGET`=0x40 -> the buffer is flushed and the next `MEM_ADDR`=0x40. Repeated with `Z`=0 -> no effect.
- Redirect to 0x80 in FETCH while ack is pending, ack 2 cycles later -> the word is dropped and no `INSTR_VALID` pulse appears. A second redirect to 0x90 during DISCARD -> the next `MEM_ADDR`=0x90.
- `PC` forced to 0xFF by redirect, then sequential fetch -> addresses 0xFF then 0x00.
- `RESET` asserted while `MEM_REQ`=1 in DISCARD -> all outputs zero the next cycle, and fetching restarts at address 0.
